// File: rtl/branch_predictor_bht.sv
// rtl/branch_predictor_bht.sv - direct-mapped 2-bit branch history table for LC-3b BR instructions
//
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   ir, pc                   fetched instruction word and its incremented PC
//   sel_branch_predict       redirect fetch to branch_target
//   branch_target            pc + (sext(ir[8:0]) << 1)
//   resolve_valid            a conditional BR resolved this cycle
//   resolve_pc               incremented PC of the resolved branch
//   resolve_taken            actual outcome of the resolved branch
//   resolve_mispredict       the earlier prediction for that branch was wrong
//   stat_lookups             saturating count of table lookups
//   stat_mispredicts         saturating count of reported mispredictions

module branch_predictor_bht #(
    parameter int INDEX_BITS     = 4,
    parameter bit STATIC_ON_MISS = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    input  logic [15:0] pc,
    output logic        sel_branch_predict,
    output logic [15:0] branch_target,
    input  logic        resolve_valid,
    input  logic [15:0] resolve_pc,
    input  logic        resolve_taken,
    input  logic        resolve_mispredict,
    output logic [15:0] stat_lookups,
    output logic [15:0] stat_mispredicts
);

    localparam int         ENTRIES  = 1 << INDEX_BITS;
    localparam int         TAG_BITS = 15 - INDEX_BITS;
    localparam logic [3:0] OP_BR    = 4'b0000;

    logic                valid_q [ENTRIES];
    logic [TAG_BITS-1:0] tag_q   [ENTRIES];
    logic [1:0]          ctr_q   [ENTRIES];

    // pc[0] is always zero for word-aligned instructions and takes no part in indexing.
    logic unused_bits;
    assign unused_bits = ^{pc[0], resolve_pc[0]};

    // Fetch-side lookup
    logic [INDEX_BITS-1:0] look_idx;
    logic [TAG_BITS-1:0]   look_tag;
    logic                  is_br;
    logic [2:0]            nzp;
    logic                  lookup_en;
    logic                  look_hit;

    assign look_idx  = pc[INDEX_BITS:1];
    assign look_tag  = pc[15:INDEX_BITS+1];
    assign is_br     = (ir[15:12] == OP_BR);
    assign nzp       = ir[11:9];
    // Never-taken and unconditional branches are decided statically and do not count as lookups.
    assign lookup_en = is_br && (nzp != 3'b000) && (nzp != 3'b111);
    assign look_hit  = valid_q[look_idx] && (tag_q[look_idx] == look_tag);

    assign branch_target = pc + {{6{ir[8]}}, ir[8:0], 1'b0};

    always_comb begin
        sel_branch_predict = 1'b0;
        if (is_br) begin
            if (nzp == 3'b111) begin
                sel_branch_predict = 1'b1;
            end else if (lookup_en) begin
                sel_branch_predict = look_hit ? ctr_q[look_idx][1] : STATIC_ON_MISS;
            end
        end
    end

    // Resolve-side update
    logic [INDEX_BITS-1:0] res_idx;
    logic [TAG_BITS-1:0]   res_tag;
    logic                  res_hit;
    logic [1:0]            res_ctr;
    logic [1:0]            res_ctr_next;

    assign res_idx = resolve_pc[INDEX_BITS:1];
    assign res_tag = resolve_pc[15:INDEX_BITS+1];
    assign res_hit = valid_q[res_idx] && (tag_q[res_idx] == res_tag);
    assign res_ctr = ctr_q[res_idx];

    always_comb begin
        res_ctr_next = res_ctr;
        if (!res_hit) begin
            // Fresh allocation starts in the weak state matching the observed outcome.
            res_ctr_next = resolve_taken ? 2'b10 : 2'b01;
        end else if (resolve_taken) begin
            if (res_ctr != 2'b11) res_ctr_next = res_ctr + 2'b01;
        end else begin
            if (res_ctr != 2'b00) res_ctr_next = res_ctr - 2'b01;
        end
    end

    // The table is read combinationally from the registered state, so a same-cycle
    // lookup of an index being updated sees the pre-update entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                ctr_q[i]   <= 2'b01;
            end
        end else if (resolve_valid) begin
            valid_q[res_idx] <= 1'b1;
            tag_q[res_idx]   <= res_tag;
            ctr_q[res_idx]   <= res_ctr_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_lookups     <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (lookup_en && (stat_lookups != 16'hFFFF)) begin
                stat_lookups <= stat_lookups + 16'd1;
            end
            if (resolve_valid && resolve_mispredict && (stat_mispredicts != 16'hFFFF)) begin
                stat_mispredicts <= stat_mispredicts + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// tb/tb_branch_predictor_bht.sv - directed self-checking bench for branch_predictor_bht

module tb_branch_predictor_bht;

    logic        clk;
    logic        rst;
    logic [15:0] ir;
    logic [15:0] pc;
    logic        sel_branch_predict;
    logic [15:0] branch_target;
    logic        resolve_valid;
    logic [15:0] resolve_pc;
    logic        resolve_taken;
    logic        resolve_mispredict;
    logic [15:0] stat_lookups;
    logic [15:0] stat_mispredicts;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [15:0] IR_BRZ4 = 16'h0404;  // BRz, offset 9'h004

    branch_predictor_bht #(.INDEX_BITS(4), .STATIC_ON_MISS(1'b1)) dut (
        .clk                (clk),
        .rst                (rst),
        .ir                 (ir),
        .pc                 (pc),
        .sel_branch_predict (sel_branch_predict),
        .branch_target      (branch_target),
        .resolve_valid      (resolve_valid),
        .resolve_pc         (resolve_pc),
        .resolve_taken      (resolve_taken),
        .resolve_mispredict (resolve_mispredict),
        .stat_lookups       (stat_lookups),
        .stat_mispredicts   (stat_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resolve(input logic [15:0] p, input logic t, input logic m);
        resolve_valid      = 1'b1;
        resolve_pc         = p;
        resolve_taken      = t;
        resolve_mispredict = m;
        tick();
        resolve_valid      = 1'b0;
        resolve_mispredict = 1'b0;
    endtask

    // Combinational lookup between edges; ir returns to a non-lookup word before the next edge.
    task automatic look(input string tag, input logic [15:0] p, input logic exp_sel);
        ir = IR_BRZ4;
        pc = p;
        #1;
        check(tag, {15'd0, sel_branch_predict}, {15'd0, exp_sel});
        ir = 16'h0000;
        #1;
    endtask

    initial begin
        rst                = 1'b1;
        ir                 = 16'h0000;
        pc                 = 16'h0000;
        resolve_valid      = 1'b0;
        resolve_pc         = 16'h0000;
        resolve_taken      = 1'b0;
        resolve_mispredict = 1'b0;
        #12;
        check("reset_lookups", stat_lookups, 16'h0000);
        check("reset_mispredicts", stat_mispredicts, 16'h0000);
        check("reset_sel_nzp000", {15'd0, sel_branch_predict}, 16'h0000);
        tick();
        rst = 1'b0;

        // First lookup: miss, static taken, target 0x3002 + 8
        ir = IR_BRZ4;
        pc = 16'h3002;
        #1;
        check("first_sel_miss", {15'd0, sel_branch_predict}, 16'h0001);
        check("first_target", branch_target, 16'h300A);
        tick();
        ir = 16'h0000;
        check("first_lookup_count", stat_lookups, 16'h0001);

        // Two not-taken resolves: allocate at 01, then 00
        resolve(16'h3002, 1'b0, 1'b1);
        look("nt1_weak_nt", 16'h3002, 1'b0);
        resolve(16'h3002, 1'b0, 1'b0);
        look("nt2_strong_nt", 16'h3002, 1'b0);
        check("lookups_unchanged", stat_lookups, 16'h0001);

        // Taken from 00: 01, 10, 11, held at 11
        resolve(16'h3002, 1'b1, 1'b1);
        look("t1_ctr01", 16'h3002, 1'b0);
        resolve(16'h3002, 1'b1, 1'b1);
        look("t2_ctr10", 16'h3002, 1'b1);
        resolve(16'h3002, 1'b1, 1'b0);
        look("t3_ctr11", 16'h3002, 1'b1);
        resolve(16'h3002, 1'b1, 1'b0);
        look("t4_ctr11_hold", 16'h3002, 1'b1);
        // One not-taken from a held 11 gives 10, a second gives 01
        resolve(16'h3002, 1'b0, 1'b1);
        look("nt_after_sat_ctr10", 16'h3002, 1'b1);
        resolve(16'h3002, 1'b0, 1'b1);
        look("nt_again_ctr01", 16'h3002, 1'b0);

        // Mispredict without valid is ignored
        resolve_mispredict = 1'b1;
        tick();
        resolve_mispredict = 1'b0;
        check("mispredicts_five", stat_mispredicts, 16'h0005);

        // Alias: 0x3022 shares index 1 with 0x3002 but carries a different tag
        resolve(16'h3022, 1'b1, 1'b0);
        look("alias_new_hit", 16'h3022, 1'b1);
        look("alias_old_miss", 16'h3002, 1'b1);
        resolve(16'h3022, 1'b0, 1'b0);
        look("alias_new_ctr01", 16'h3022, 1'b0);

        // Static cases and non-BR opcode, with 0x3022 currently predicting not-taken
        ir = 16'h0004; pc = 16'h3022; #1;
        check("nzp000_sel", {15'd0, sel_branch_predict}, 16'h0000);
        ir = 16'h0E04; #1;
        check("nzp111_sel", {15'd0, sel_branch_predict}, 16'h0001);
        ir = 16'h0FFF; pc = 16'h0000; #1;
        check("neg_offset_target", branch_target, 16'hFFFE);
        ir = 16'h1404; pc = 16'h3002; #1;
        check("non_br_sel", {15'd0, sel_branch_predict}, 16'h0000);
        ir = 16'h0000;
        tick();
        check("static_no_lookup_count", stat_lookups, 16'h0001);

        // Same-cycle lookup and update of 0x3022: lookup sees the pre-update 01
        ir = IR_BRZ4; pc = 16'h3022;
        resolve_valid = 1'b1; resolve_pc = 16'h3022; resolve_taken = 1'b1;
        #1;
        check("same_cycle_pre_update", {15'd0, sel_branch_predict}, 16'h0000);
        tick();
        resolve_valid = 1'b0;
        #1;
        check("same_cycle_post_update", {15'd0, sel_branch_predict}, 16'h0001);
        ir = 16'h0000;
        check("same_cycle_lookup_count", stat_lookups, 16'h0002);
        resolve(16'h3022, 1'b0, 1'b0);
        look("pre_reset_ctr01", 16'h3022, 1'b0);
        check("pre_reset_mispredicts", stat_mispredicts, 16'h0005);

        // Asynchronous reset pulse between edges
        rst = 1'b1;
        #1;
        check("async_rst_lookups", stat_lookups, 16'h0000);
        check("async_rst_mispredicts", stat_mispredicts, 16'h0000);
        look("async_rst_miss", 16'h3022, 1'b1);

        // Edge under reset with a resolve and a lookup pending: both discarded
        ir = IR_BRZ4; pc = 16'h3022;
        resolve_valid = 1'b1; resolve_pc = 16'h3022; resolve_taken = 1'b0; resolve_mispredict = 1'b1;
        tick();
        rst = 1'b0;
        resolve_valid = 1'b0; resolve_mispredict = 1'b0;
        ir = 16'h0000;
        #1;
        check("rst_edge_lookups", stat_lookups, 16'h0000);
        check("rst_edge_mispredicts", stat_mispredicts, 16'h0000);
        look("rst_edge_update_discarded", 16'h3022, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_predictor_bht.md
BRANCH_PREDICTOR_BHT -- requirements
Module: branch_predictor_bht

Interface
REQ-001 Parameter INDEX_BITS, default 4; table holds 2**INDEX_BITS entries.
REQ-002 Parameter STATIC_ON_MISS, default 1; 1 predicts taken on a table miss, 0 predicts not-taken.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 ir  input  16  fetched instruction word (lc3b_word).
REQ-006 pc  input  16  incremented PC of the fetched instruction (address+2).
REQ-007 sel_branch_predict  output  1  redirect fetch to branch_target.
REQ-008 branch_target  output  16  pc + sext(ir[8:0]) shifted left by 1, 16-bit wrap.
REQ-009 resolve_valid  input  1  a conditional BR resolved this cycle.
REQ-010 resolve_pc  input  16  incremented PC of the resolved branch.
REQ-011 resolve_taken  input  1  actual outcome of the resolved branch.
REQ-012 resolve_mispredict  input  1  the earlier prediction for this branch was wrong.
REQ-013 stat_lookups, stat_mispredicts  output  16 each  performance counters.

Function
REQ-014 Index = pc[INDEX_BITS:1]; tag = pc[15:INDEX_BITS+1]; each entry = valid bit, tag, 2-bit counter.
REQ-015 Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T; predict taken when bit 1 is set.
REQ-016 Lookup is combinational, zero latency: branch_target is always driven; sel_branch_predict is 0 unless ir[15:12]==op_br.
REQ-017 op_br with ir[11:9]==000: sel_branch_predict=0 always; the table is not consulted.
REQ-018 op_br with ir[11:9]==111: sel_branch_predict=1 always; the table is not consulted.
REQ-019 Other op_br: on a hit (valid and tag match), sel_branch_predict = counter bit 1; on a miss, sel_branch_predict = STATIC_ON_MISS.
REQ-020 On a resolve_valid hit, the counter saturates: +1 if resolve_taken (11 holds at 11), -1 if not taken (00 holds at 00).
REQ-021 On a resolve_valid miss, the entry is allocated/overwritten: valid=1, new tag, counter 10 if taken, 01 if not taken.
REQ-022 Same-cycle lookup and update of one index: lookup returns the pre-update entry; no bypass.
REQ-023 stat_lookups increments once per clk edge in which a REQ-019 lookup occurs; stat_mispredicts increments per edge with resolve_valid && resolve_mispredict; both saturate at 16'hFFFF.
REQ-024 resolve_mispredict without resolve_valid is ignored.
REQ-025 Unconditional (nzp=111) and never-taken (nzp=000) branches are not presented on resolve_valid; if they are, they update the table normally.

Reset
REQ-026 rst asserted immediately clears all valid bits, sets all counters to 01, and zeroes stat_lookups and stat_mispredicts, independent of clk.
REQ-027 While rst is high, no table or counter update occurs; sel_branch_predict follows REQ-016..019 with an all-miss table.
REQ-028 rst asserted in the same cycle as resolve_valid discards the update.

Verification
REQ-029 After reset, ir=BRz offset 9'h004, pc=16'h3002 -> sel_branch_predict=1 (miss, STATIC_ON_MISS=1), branch_target=16'h300A, stat_lookups increments to 1 at the next edge.
REQ-030 Resolve pc=16'h3002 not-taken twice, then look up the same branch -> entry 01 then 00; sel_branch_predict=0.
REQ-031 From 00, resolve taken three times -> 01, 10, 11; a fourth taken resolve holds 11; the lookup predicts taken from the second taken resolve onward.
REQ-032 Alias: pc=16'h3002 and pc=16'h3022 (INDEX_BITS=4, same index, different tag) -> a resolve of 3022 replaces the 3002 entry; a lookup of 3002 then misses.
REQ-033 ir nzp=000 -> sel_branch_predict=0; nzp=111 -> 1 regardless of table state; negative offset 9'h1FF with pc=16'h0000 -> branch_target=16'hFFFE.
REQ-034 Pulse rst asynchronously mid-run with stat_mispredicts=5 -> counters read 0 before the next clk edge, and all lookups miss.
